// File: rtl/serial_pattern_detect.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : serial_pattern_detect
//  Description : Serial bit-pattern detector. Programmable LEN-bit pattern
//                with a per-bit don't-care mask, overlapping or
//                non-overlapping match mode, valid-qualified serial input and
//                a saturating match counter with sticky overflow flag.
//  Ports       : sys_clk, rst (async, active-low)
//                enable, dat_valid, dat_in        - serial input side
//                cfg_we, cfg_pattern, cfg_mask,
//                cfg_overlap                      - configuration load
//                clr_cnt                          - counter clear
//                find                             - one-cycle match pulse
//                match_cnt, cnt_ovf               - match statistics
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_pattern_detect #(
    parameter int             LEN     = 8,
    parameter int             CNT_W   = 16,
    parameter logic [LEN-1:0] PAT_RST = LEN'(8'hD3),
    parameter logic [LEN-1:0] MSK_RST = '1,
    parameter logic           OVL_RST = 1'b1
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             dat_valid,
    input  logic             dat_in,
    input  logic             cfg_we,
    input  logic [LEN-1:0]   cfg_pattern,
    input  logic [LEN-1:0]   cfg_mask,
    input  logic             cfg_overlap,
    input  logic             clr_cnt,
    output logic             find,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_ovf
);

    localparam int             FC_W       = $clog2(LEN + 1);
    localparam logic [FC_W-1:0] C_LEN     = FC_W'(LEN);
    localparam logic [FC_W-1:0] C_LEN_M1  = FC_W'(LEN - 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_HUNT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [FC_W-1:0]  r_fcnt;
    logic [FC_W-1:0]  w_fcnt_nxt;
    logic [FC_W-1:0]  w_fcnt_inc;
    // Only the LEN-1 most recent bits are kept; the incoming bit completes
    // the LEN-bit comparison window.
    logic [LEN-2:0]   r_sreg;
    logic [LEN-1:0]   r_pattern;
    logic [LEN-1:0]   r_mask;
    logic             r_overlap;
    logic             r_find;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;

    logic             w_accept;
    logic [LEN-1:0]   w_nxt;
    logic             w_hit;

    // A bit presented in a configuration cycle is dropped with the history.
    assign w_accept   = enable & dat_valid & ~cfg_we;
    assign w_nxt      = {r_sreg, dat_in};
    assign w_hit      = w_accept && (r_state == ST_HUNT) &&
                        (((w_nxt ^ r_pattern) & r_mask) == '0);
    assign w_fcnt_inc = (w_accept && (r_fcnt != C_LEN)) ? r_fcnt + FC_W'(1) : r_fcnt;

    // ------------------------------------------------------------------
    // Next-state / fill-count logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        if (!enable) begin
            w_state_nxt = ST_IDLE;
            w_fcnt_nxt  = '0;
        end else if (cfg_we) begin
            w_state_nxt = ST_FILL;
            w_fcnt_nxt  = '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_FILL: begin
                    // Comparison starts once LEN-1 bits of history exist; the
                    // LEN-th bit is then checked as it arrives.
                    w_fcnt_nxt  = w_fcnt_inc;
                    w_state_nxt = (w_fcnt_inc >= C_LEN_M1) ? ST_HUNT : ST_FILL;
                end
                ST_HUNT: begin
                    if (w_hit && !r_overlap) begin
                        w_state_nxt = ST_FILL;
                        w_fcnt_nxt  = '0;
                    end else begin
                        w_fcnt_nxt  = w_fcnt_inc;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_fcnt_nxt  = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State, history and configuration registers
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_fcnt    <= '0;
            r_sreg    <= '0;
            r_pattern <= PAT_RST;
            r_mask    <= MSK_RST;
            r_overlap <= OVL_RST;
            r_find    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_fcnt  <= w_fcnt_nxt;
            r_find  <= w_hit;
            if (cfg_we) begin
                r_sreg    <= '0;
                r_pattern <= cfg_pattern;
                r_mask    <= cfg_mask;
                r_overlap <= cfg_overlap;
            end else if (w_accept) begin
                r_sreg <= w_nxt[LEN-2:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating match counter; a hit coinciding with a clear is kept.
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (clr_cnt) begin
            r_cnt <= w_hit ? CNT_W'(1) : '0;
            r_ovf <= 1'b0;
        end else if (w_hit) begin
            if (r_cnt == C_CNT_MAX) begin
                r_ovf <= 1'b1;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign find      = r_find;
    assign match_cnt = r_cnt;
    assign cnt_ovf   = r_ovf;

endmodule
`default_nettype wire
